// File: rtl/mmio_bus_ctrl.sv
`default_nettype none
// ============================================================================
// mmio_bus_ctrl : MMIO sub-bus controller, prefix decode, timeout watchdog,
//                 sticky error capture and force_trap override
// Revision      : 1.0
// ============================================================================
module mmio_bus_ctrl #(
    parameter int                     NUM_CORES      = 7,
    parameter logic [NUM_CORES*6-1:0] PREFIX_MAP     = {6'h3f, 6'h10, 6'h04, 6'h03, 6'h02, 6'h01, 6'h00},
    parameter int                     TIMEOUT_CYCLES = 255,
    parameter logic [31:0]            TRAP_WORD      = 32'h0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cpu_valid,
    input  logic [31:0]             cpu_addr,
    input  logic [3:0]              cpu_wstrb,
    input  logic [31:0]             cpu_wdata,
    output logic                    cpu_ready,
    output logic [31:0]             cpu_rdata,
    input  logic                    force_trap,
    output logic [NUM_CORES-1:0]    core_cs,
    output logic                    core_we,
    output logic [7:0]              core_address,
    output logic [31:0]             core_write_data,
    input  logic [NUM_CORES*32-1:0] core_read_data,
    input  logic [NUM_CORES-1:0]    core_ready,
    input  logic                    err_clear,
    output logic                    err_unmapped,
    output logic                    err_timeout,
    output logic [31:0]             err_addr
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int               SEL_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_unmapped_q, err_unmapped_d;
    logic              err_timeout_q, err_timeout_d;
    logic [31:0]       err_addr_q, err_addr_d;

    logic              w_hit;
    logic [SEL_W-1:0]  w_hit_idx;
    logic              w_set_unmapped;
    logic              w_set_timeout;

    // Scan from the top down so the lowest matching channel is the one left standing.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (cpu_addr[29:24] == PREFIX_MAP[i*6 +: 6]) begin
                w_hit     = 1'b1;
                w_hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        cnt_d          = cnt_q;
        rdata_d        = rdata_q;
        w_set_unmapped = 1'b0;
        w_set_timeout  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_valid) begin
                    if (force_trap) begin
                        rdata_d = TRAP_WORD;
                        state_d = RESP;
                    end else if (w_hit) begin
                        sel_d   = w_hit_idx;
                        cnt_d   = '0;
                        state_d = ACCESS;
                    end else begin
                        rdata_d        = '0;
                        w_set_unmapped = 1'b1;
                        state_d        = RESP;
                    end
                end
            end
            ACCESS: begin
                if (!cpu_valid) begin
                    state_d = IDLE;
                end else if (core_ready[sel_q]) begin
                    rdata_d = core_read_data[{sel_q, 5'b0} +: 32];
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d       = '0;
                    w_set_timeout = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A new error in the same cycle as err_clear survives the clear.
    always_comb begin
        err_unmapped_d = (err_unmapped_q & ~err_clear) | w_set_unmapped;
        err_timeout_d  = (err_timeout_q  & ~err_clear) | w_set_timeout;
        err_addr_d     = err_clear ? 32'h0 : err_addr_q;
        if ((w_set_unmapped || w_set_timeout) &&
            (err_clear || !(err_unmapped_q || err_timeout_q))) begin
            err_addr_d = cpu_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            sel_q          <= '0;
            cnt_q          <= '0;
            rdata_q        <= '0;
            err_unmapped_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_addr_q     <= '0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            cnt_q          <= cnt_d;
            rdata_q        <= rdata_d;
            err_unmapped_q <= err_unmapped_d;
            err_timeout_q  <= err_timeout_d;
            err_addr_q     <= err_addr_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_cs
        assign core_cs[gi] = (state_q == ACCESS) && (sel_q == SEL_W'(gi));
    end

    assign cpu_ready       = (state_q == RESP);
    assign cpu_rdata       = (state_q == RESP) ? rdata_q : 32'h0;
    assign core_we         = |cpu_wstrb;
    assign core_address    = cpu_addr[9:2];
    assign core_write_data = cpu_wdata;
    assign err_unmapped    = err_unmapped_q;
    assign err_timeout     = err_timeout_q;
    assign err_addr        = err_addr_q;

endmodule
`default_nettype wire

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
Parametrised MMIO sub-bus controller between the picorv32 memory interface and N MMIO cores.
- Decodes the core prefix in cpu_addr[29:24] against a per-channel prefix map.
- Drives a one-hot chip-select bundle and waits for the selected core's ready.
- Returns a registered response to the CPU.
- Beyond the existing single-cycle decode mux, it adds a per-access timeout watchdog, unmapped-prefix and timeout error reporting with a sticky error address, and a force_trap override.

Parameters:
NUM_CORES, 7, number of MMIO core channels (1..16)
PREFIX_MAP, {6'h3f,6'h10,6'h04,6'h03,6'h02,6'h01,6'h00}, NUM_CORES*6-bit flat map; slice i = prefix of channel i
TIMEOUT_CYCLES, 255, maximum cycles in ACCESS before the access is aborted (1..65535)
TRAP_WORD, 32'h0, read data returned when force_trap is asserted (illegal instruction)

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous, active-low reset
cpu_valid  input  1  CPU access request; address and data stable while high
cpu_addr  input  32  CPU byte address; only the MMIO area is routed here
cpu_wstrb  input  4  byte write strobes; 0 = read
cpu_wdata  input  32  write data
cpu_ready  output  1  one-cycle access completion pulse
cpu_rdata  output  32  read data, valid while cpu_ready=1
force_trap  input  1  when high, the access completes with TRAP_WORD and no core is selected
core_cs  output  NUM_CORES  one-hot chip selects
core_we  output  1  |cpu_wstrb
core_address  output  8  cpu_addr[9:2]
core_write_data  output  32  cpu_wdata
core_read_data  input  NUM_CORES*32  flat read data; slice i belongs to channel i
core_ready  input  NUM_CORES  per-core ready
err_clear  input  1  clears sticky error state
err_unmapped  output  1  sticky: access to a prefix not in PREFIX_MAP
err_timeout  output  1  sticky: a core failed to assert ready within TIMEOUT_CYCLES
err_addr  output  32  cpu_addr of the first error since the last clear

Behaviour:
Reset values:
- All outputs 0: cpu_ready, cpu_rdata, core_cs, err_* and err_addr.
- FSM returns to IDLE; timeout counter is 0.

FSM states are IDLE, ACCESS and RESP.

IDLE, when cpu_valid=1:
- force_trap=1: load rdata_reg=TRAP_WORD, go to RESP. No error is flagged and no cs is asserted. force_trap has priority over decode.
- Prefix matches channel i: register sel=i, clear the counter, go to ACCESS. If prefixes are duplicated, the lowest matching index wins.
- No prefix match: rdata_reg=0, set err_unmapped, go to RESP.

ACCESS:
- core_cs[sel]=1 (driven from registered sel); all other cs bits 0.
- core_ready[sel]=1: rdata_reg=core_read_data slice sel, go to RESP. Ready from unselected cores is ignored.
- Otherwise the counter increments. When counter==TIMEOUT_CYCLES-1 with no ready: rdata_reg=0, set err_timeout, go to RESP, and core_cs drops the next cycle.
- cpu_valid=0 (abandoned access): go to IDLE with no cpu_ready and no error.

RESP:
- cpu_ready=1 and cpu_rdata=rdata_reg for exactly one cycle, then IDLE.
- cpu_rdata returns to 0 outside RESP.
- A new request is accepted no earlier than the cycle after RESP; cpu_valid held high through RESP is not re-accepted.

Latency and pass-through:
- A core with a combinational ready (asserted in the first ACCESS cycle) gives valid→cpu_ready = 2 cycles.
- A force_trap or unmapped access also takes 2 cycles.
- Writes complete the same way; cpu_rdata carries the core's read data (don't-care).
- core_we, core_address and core_write_data pass through combinationally at all times.

Errors:
- err_addr is captured only when both sticky flags are currently 0. A later error sets its own flag but keeps the first address.
- err_clear=1 clears both flags and err_addr. An error raised in the same cycle as err_clear wins: the flag is set and the address is captured.

Boundary cases:
- Counter width is clog2(TIMEOUT_CYCLES+1).
- TIMEOUT_CYCLES=1 aborts unless ready arrives in the first ACCESS cycle.
- reset_n low in any state forces IDLE on the next edge and deasserts cs and cpu_ready.

Test Plan:
- Read prefix 6'h03 (channel 3); core 3 returns 32'hA5A5_0003 with ready in the first ACCESS cycle → core_cs=7'b0001000 for 1 cycle; cpu_ready 2 cycles after valid with rdata 32'hA5A5_0003.
- Write to prefix 6'h3f, wstrb 4'hF, wdata 32'hDEAD_BEEF; core 6 asserts ready after 5 wait cycles → core_we=1, core_write_data passes through, cpu_ready 7 cycles after valid, no error.
- Access to prefix 6'h20 at address 32'hE000_0010 → no cs asserted; cpu_ready after 2 cycles with rdata 0; err_unmapped=1; err_addr=32'hE000_0010.
- Core 1 never asserts ready, TIMEOUT_CYCLES=255 → cs high for exactly 255 cycles; cpu_ready with rdata 0; err_timeout=1; err_addr keeps the earlier error address if one is already set.
- force_trap=1 on an access to prefix 6'h00 → no cs asserted; cpu_rdata=32'h0 (TRAP_WORD) with cpu_ready after 2 cycles; no error flags.
- err_clear pulsed in the same cycle as a new unmapped error → err_unmapped stays 1 and err_addr takes the new address. reset_n asserted mid-ACCESS → cs and cpu_ready are 0 on the next edge and the FSM is in IDLE.
